// File: rtl/key_pkg.sv
// Shared state encoding and debounce-time constants for the key filter.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_fsm_e;

  // 20 ms at 50 MHz for hardware; a short window keeps simulation fast.
  localparam logic [24:0] CNT_MAX_HW  = 25'd999_999;
  localparam logic [24:0] CNT_MAX_SIM = 25'd24;

  function automatic int cnt_width(input logic [24:0] cnt_max);
    return (cnt_max == 25'd0) ? 1 : $clog2({1'b0, cnt_max} + 26'd1);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// Single-key debounce channel: two-flop synchronizer, four-state filter FSM
// and stability counter with registered level and event outputs.
module key_filter_ch
  import key_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = CNT_MAX_HW
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press_flag,
  output logic key_release_flag
);

  localparam int              CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]   CNT_END = CNT_MAX[CW-1:0];

  logic          sync_s1_reg;
  logic          sync_s2_reg;
  logic          key_sync;
  key_fsm_e      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          key_state_reg, key_state_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;

  assign key_sync = sync_s2_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // Synchronizer starts in the released (high) state.
      sync_s1_reg   <= 1'b1;
      sync_s2_reg   <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      key_state_reg <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
    end else begin
      sync_s1_reg   <= key_in;
      sync_s2_reg   <= sync_s1_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_state_reg <= key_state_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    key_state_next = key_state_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_sync) begin
          state_next = FILT_DN;
          cnt_next   = '0;
        end
      end
      FILT_DN: begin
        if (key_sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_END) begin
          state_next     = DOWN;
          cnt_next       = '0;
          press_next     = 1'b1;
          key_state_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DOWN: begin
        if (key_sync) begin
          state_next = FILT_UP;
          cnt_next   = '0;
        end
      end
      FILT_UP: begin
        // A low sample while filtering a release means the key is still held.
        if (!key_sync) begin
          state_next = DOWN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_END) begin
          state_next     = IDLE;
          cnt_next       = '0;
          release_next   = 1'b1;
          key_state_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key_state        = key_state_reg;
  assign key_press_flag   = press_reg;
  assign key_release_flag = release_reg;

endmodule

// File: rtl/key_filter.sv
// Debounces KEY_W active-low push-buttons into a clean level plus
// single-cycle press and release events, one independent channel per key.
module key_filter
  import key_pkg::*;
#(
  parameter int          KEY_W   = 3,
  parameter logic [24:0] CNT_MAX = CNT_MAX_HW
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press_flag,
  output logic [KEY_W-1:0] key_release_flag
);

  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_ch
      key_filter_ch #(
        .CNT_MAX (CNT_MAX)
      ) u_ch (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .key_in           (key_in[gi]),
        .key_state        (key_state[gi]),
        .key_press_flag   (key_press_flag[gi]),
        .key_release_flag (key_release_flag[gi])
      );
    end
  endgenerate

endmodule
